// File: rtl/pipe_arith_pkg.sv
// Shared constants for the three-stage arithmetic streaming pipeline.
package pipe_arith_pkg;

    localparam int W_DEF    = 10;
    localparam int N_STAGES = 3;
    // Cycles from input accept to out_valid when the consumer never stalls.
    localparam int LATENCY  = N_STAGES;

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage register: a valid bit plus a DW-bit data slice.
import pipe_arith_pkg::*;

module pipe_stage_reg #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          en,
    input  logic          v_in,
    input  logic [DW-1:0] d_in,
    output logic          v_out,
    output logic [DW-1:0] d_out
);

    // Data only loads for a real item, so bubbles and flushes leave the last value in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_out <= 1'b0;
            d_out <= '0;
        end else begin
            if (flush) begin
                v_out <= 1'b0;
            end else if (en) begin
                v_out <= v_in;
            end
            if (en && v_in && !flush) begin
                d_out <= d_in;
            end
        end
    end

endmodule

// File: rtl/pipe_arith_hs.sv
// Streaming engine computing F = ((A+B)+(C-D))*D modulo 2^W over three
// handshaked stages with bubble collapsing, back-pressure and flush.
import pipe_arith_pkg::*;

module pipe_arith_hs #(
    parameter int W       = W_DEF,
    parameter int REG_OUT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic [W-1:0] in_c,
    input  logic [W-1:0] in_d,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_f
);

    generate
        if (REG_OUT != 1) begin : g_bad_reg_out
            $error("pipe_arith_hs: REG_OUT must be 1");
        end
    endgenerate

    logic         v1, v2, v3;
    logic         en1, en2, en3;
    logic [W-1:0] x1, x2, d1, x3, d2, f;
    logic [W-1:0] x1_n, x2_n, x3_n, f_n;

    // Handshake: a transfer happens on a clock edge where valid and ready are
    // both high; ready never depends on valid of the same interface, and a
    // stage may load whenever it is empty or its successor is loading.
    assign en3      = !v3 || out_ready;
    assign en2      = !v2 || en3;
    assign en1      = !v1 || en2;
    assign in_ready = en1 || rst;

    assign x1_n = in_a + in_b;
    assign x2_n = in_c - in_d;
    assign x3_n = x1 + x2;
    assign f_n  = x3 * d2;

    pipe_stage_reg #(.DW(3*W)) u_s1 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .en    (en1),
        .v_in  (in_valid),
        .d_in  ({x1_n, x2_n, in_d}),
        .v_out (v1),
        .d_out ({x1, x2, d1})
    );

    pipe_stage_reg #(.DW(2*W)) u_s2 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .en    (en2),
        .v_in  (v1),
        .d_in  ({x3_n, d1}),
        .v_out (v2),
        .d_out ({x3, d2})
    );

    pipe_stage_reg #(.DW(W)) u_s3 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .en    (en3),
        .v_in  (v2),
        .d_in  (f_n),
        .v_out (v3),
        .d_out (f)
    );

    assign out_valid = v3;
    assign out_f     = f;

endmodule

// File: tb/tb_pipe_arith_hs.sv
// Bench for pipe_arith_hs: fixed vector table, random streams with back-pressure,
// flush and reset corner sequences, all checked through an expected-value queue.
module tb_pipe_arith_hs;
    import pipe_arith_pkg::*;

    localparam int W = 10;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] c;
        logic [W-1:0] d;
        logic [W-1:0] f;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] in_a = '0, in_b = '0, in_c = '0, in_d = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_f;

    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           or_mode = 0;
    int           run_len = 0;
    int           max_run = 0;
    int           last_pop_cyc = -10;
    logic [W-1:0] cur_exp = '0;
    logic [W-1:0] exp_q[$];

    pipe_arith_hs #(.W(W), .REG_OUT(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .in_d      (in_d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_f     (out_f)
    );

    // Clock and cycle counter
    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Consumer ready: 0 = always ready, 1 = stalled, 2 = random 50%
    initial forever begin
        @(posedge clk);
        #2;
        case (or_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [W-1:0] a, b, c, d);
        logic [W-1:0] s, t, u;
        s = a + b;
        t = c - d;
        u = s + t;
        return u * d;
    endfunction

    // Scoreboard: sampled on the falling edge, where handshake signals are settled
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1 && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got %0d expected no output (t=%0t)", out_f, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("out_f", 32'(out_f), 32'(e));
                end
                run_len = (last_pop_cyc == cyc - 1) ? run_len + 1 : 1;
                last_pop_cyc = cyc;
                if (run_len > max_run) max_run = run_len;
            end
            if (rst || flush) begin
                exp_q.delete();
            end else if (in_valid && in_ready) begin
                exp_q.push_back(cur_exp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_item(input logic [W-1:0] a, b, c, d, f);
        in_a = a; in_b = b; in_c = c; in_d = d;
        cur_exp = f;
    endtask

    task automatic set_rand_item();
        logic [W-1:0] a, b, c, d;
        a = W'($urandom_range(0, 1023));
        b = W'($urandom_range(0, 1023));
        c = W'($urandom_range(0, 1023));
        d = W'($urandom_range(0, 1023));
        set_item(a, b, c, d, model(a, b, c, d));
    endtask

    // Holds in_valid until accepted; returns the number of cycles it took.
    task automatic send(output int waited);
        logic acc;
        acc = 1'b0;
        waited = 0;
        in_valid = 1'b1;
        while (!acc && waited < 100) begin
            @(negedge clk);
            acc = in_ready;
            step();
            waited++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got no in_ready expected accept within 100 cycles");
        end
    endtask

    // Called right after an accept into an empty, unstalled pipe.
    task automatic lat_check(input string name);
        for (int k = 1; k <= LATENCY; k++) begin
            @(negedge clk);
            check($sformatf("%s_ov_c%0d", name, k), 32'(out_valid), (k == LATENCY) ? 32'd1 : 32'd0);
            step();
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            step();
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    vec_t vecs[8];

    initial begin
        int w;
        int stalls;
        int acc;
        logic adv;

        vecs[0] = '{a: 10'd3,    b: 10'd4,    c: 10'd10,   d: 10'd2,    f: 10'd30};
        vecs[1] = '{a: 10'd1000, b: 10'd100,  c: 10'd0,    d: 10'd1,    f: 10'd75};
        vecs[2] = '{a: 10'd0,    b: 10'd0,    c: 10'd0,    d: 10'd0,    f: 10'd0};
        vecs[3] = '{a: 10'd1023, b: 10'd1,    c: 10'd5,    d: 10'd3,    f: 10'd6};
        vecs[4] = '{a: 10'd5,    b: 10'd5,    c: 10'd2,    d: 10'd7,    f: 10'd35};
        vecs[5] = '{a: 10'd1023, b: 10'd1023, c: 10'd1023, d: 10'd1023, f: 10'd2};
        vecs[6] = '{a: 10'd100,  b: 10'd200,  c: 10'd50,   d: 10'd10,   f: 10'd328};
        vecs[7] = '{a: 10'd512,  b: 10'd0,    c: 10'd0,    d: 10'd2,    f: 10'd1020};

        // Reset state
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_f", 32'(out_f), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        step();

        // Table vectors, each with exact latency
        foreach (vecs[i]) begin
            set_item(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, vecs[i].f);
            send(w);
            lat_check($sformatf("vec%0d", i));
        end
        drain("table_drain");

        // Back-to-back random stream, no back-pressure
        max_run = 0;
        stalls = 0;
        for (int i = 0; i < 20; i++) begin
            set_rand_item();
            send(w);
            stalls += w - 1;
        end
        drain("b2b_drain");
        check("b2b_stalls", 32'(stalls), 32'd0);
        check("b2b_consecutive", 32'(max_run >= 20), 32'd1);

        // Consumer stall for 6 cycles while the producer streams
        or_mode = 1;
        step();
        acc = 0;
        set_rand_item();
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            @(negedge clk);
            adv = in_ready;
            step();
            if (adv) begin
                acc++;
                set_rand_item();
            end
        end
        in_valid = 1'b0;
        check("stall_accepts", 32'(acc), 32'd3);
        @(negedge clk);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_out_valid", 32'(out_valid), 32'd1);
        step();
        or_mode = 0;
        drain("stall_drain");

        // Random consumer ready over 1000 items with occasional producer gaps
        or_mode = 2;
        for (int i = 0; i < 1000; i++) begin
            set_rand_item();
            send(w);
            if ($urandom_range(0, 3) == 0) step();
        end
        drain("rand_drain");
        or_mode = 0;

        // Flush with three items in flight
        or_mode = 1;
        step();
        for (int i = 0; i < 3; i++) begin
            set_rand_item();
            send(w);
        end
        flush = 1'b1;
        set_rand_item();
        in_valid = 1'b1;
        @(negedge clk);
        check("flush_cycle_out_valid", 32'(out_valid), 32'd1);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        or_mode = 0;
        @(negedge clk);
        check("post_flush_out_valid", 32'(out_valid), 32'd0);
        step();
        set_item(10'd3, 10'd4, 10'd10, 10'd2, 10'd30);
        send(w);
        lat_check("post_flush");
        drain("flush_drain");

        // Reset mid-stream
        set_rand_item();
        send(w);
        set_rand_item();
        send(w);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_f", 32'(out_f), 32'd0);
        repeat (5) step();

        // Reset and flush together: reset must also clear the data registers
        or_mode = 1;
        step();
        set_item(10'd3, 10'd4, 10'd10, 10'd2, 10'd30);
        send(w);
        for (int i = 0; i < 2; i++) begin
            set_rand_item();
            send(w);
        end
        @(negedge clk);
        check("pre_rstflush_out_f", 32'(out_f), 32'd30);
        step();
        rst = 1'b1;
        flush = 1'b1;
        step();
        rst = 1'b0;
        flush = 1'b0;
        or_mode = 0;
        @(negedge clk);
        check("rstflush_out_valid", 32'(out_valid), 32'd0);
        check("rstflush_out_f", 32'(out_f), 32'd0);
        step();

        set_rand_item();
        send(w);
        lat_check("final");
        drain("final_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
